// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - alloc/resolve/train/recover bundle for branch_resolve_queue
interface branch_resolve_queue_if #(
  parameter int GH    = 4,
  parameter int DEPTH = 8
);
  localparam int TAGW = $clog2(DEPTH);

  logic            alloc_valid_i;
  logic [31:0]     alloc_pc_i;
  logic            alloc_pred_taken_i;
  logic [31:0]     alloc_pred_target_i;
  logic [GH-1:0]   alloc_ghr_snapshot_i;
  logic            alloc_ready_o;
  logic [TAGW-1:0] alloc_tag_o;

  logic            resolve_valid_i;
  logic [TAGW-1:0] resolve_tag_i;
  logic            resolve_actual_taken_i;
  logic [31:0]     resolve_actual_target_i;

  logic            train_valid_o;
  logic [31:0]     train_pc_o;
  logic            train_actual_taken_o;
  logic [31:0]     train_actual_target_o;
  logic [GH-1:0]   train_ghr_snapshot_o;

  logic            recover_mispredict_pulse_o;
  logic [GH-1:0]   recover_ghr_snapshot_o;
  logic [31:0]     redirect_pc_o;

  logic [31:0]     stat_retired_o;
  logic [31:0]     stat_mispredict_o;

  // queue side
  modport slave (
    input  alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i, alloc_ghr_snapshot_i,
    output alloc_ready_o, alloc_tag_o,
    input  resolve_valid_i, resolve_tag_i, resolve_actual_taken_i, resolve_actual_target_i,
    output train_valid_o, train_pc_o, train_actual_taken_o, train_actual_target_o, train_ghr_snapshot_o,
    output recover_mispredict_pulse_o, recover_ghr_snapshot_o, redirect_pc_o,
    output stat_retired_o, stat_mispredict_o
  );

  // fetch/execute side
  modport master (
    output alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i, alloc_ghr_snapshot_i,
    input  alloc_ready_o, alloc_tag_o,
    output resolve_valid_i, resolve_tag_i, resolve_actual_taken_i, resolve_actual_target_i,
    input  train_valid_o, train_pc_o, train_actual_taken_o, train_actual_target_o, train_ghr_snapshot_o,
    input  recover_mispredict_pulse_o, recover_ghr_snapshot_o, redirect_pc_o,
    input  stat_retired_o, stat_mispredict_o
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch tracking queue with mispredict squash/recovery; BRQ_STATS_EN enables retire/mispredict counters
module branch_resolve_queue #(
  parameter int GH    = 4,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  branch_resolve_queue_if.slave bus
);
  localparam int TAGW = $clog2(DEPTH);
  localparam int PTRW = TAGW + 1;

  typedef struct packed {
    logic          valid;
    logic          resolved;
    logic [31:0]   pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [GH-1:0] snap;
    logic          act_taken;
    logic [31:0]   act_target;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic            train_valid_q, train_valid_d;
  logic [31:0]     train_pc_q, train_pc_d;
  logic            train_taken_q, train_taken_d;
  logic [31:0]     train_target_q, train_target_d;
  logic [GH-1:0]   train_snap_q, train_snap_d;
  logic            rec_pulse_q, rec_pulse_d;
  logic [GH-1:0]   rec_ghr_q, rec_ghr_d;
  logic [31:0]     redirect_q, redirect_d;

  logic [PTRW-1:0] occ;
  logic [TAGW-1:0] head_idx, tail_idx, res_off, rel;
  logic            alloc_ready, res_hit, mis, mis_fire, retire, alloc_fire;
  entry_t          r_ent, h_ent;

  assign occ         = tail_q - head_q;
  assign alloc_ready = (occ != PTRW'(DEPTH));
  assign head_idx    = head_q[TAGW-1:0];
  assign tail_idx    = tail_q[TAGW-1:0];

  // Queue update: retire at head, resolve/squash by tag, alloc at tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d         = head_q;
    tail_d         = tail_q;
    train_valid_d  = 1'b0;
    train_pc_d     = train_pc_q;
    train_taken_d  = train_taken_q;
    train_target_d = train_target_q;
    train_snap_d   = train_snap_q;
    rec_pulse_d    = 1'b0;
    rec_ghr_d      = rec_ghr_q;
    redirect_d     = redirect_q;
    rel            = '0;

    r_ent   = ent_q[bus.resolve_tag_i];
    h_ent   = ent_q[head_idx];
    res_hit = bus.resolve_valid_i && r_ent.valid && !r_ent.resolved;
    mis     = (r_ent.pred_taken != bus.resolve_actual_taken_i) ||
              (r_ent.pred_taken && bus.resolve_actual_taken_i &&
               (r_ent.pred_target != bus.resolve_actual_target_i));
    mis_fire   = res_hit && mis;
    // Resolved bit comes from the register, so a same-cycle resolve cannot retire.
    retire     = h_ent.valid && h_ent.resolved;
    // A same-cycle alloc is on the wrong path when a mispredict is being recovered.
    alloc_fire = bus.alloc_valid_i && alloc_ready && !mis_fire;
    res_off    = bus.resolve_tag_i - head_idx;

    if (retire) begin
      ent_d[head_idx].valid = 1'b0;
      head_d         = head_q + PTRW'(1);
      train_valid_d  = 1'b1;
      train_pc_d     = h_ent.pc;
      train_taken_d  = h_ent.act_taken;
      train_target_d = h_ent.act_target;
      train_snap_d   = h_ent.snap;
    end

    if (res_hit) begin
      ent_d[bus.resolve_tag_i].resolved   = 1'b1;
      ent_d[bus.resolve_tag_i].act_taken  = bus.resolve_actual_taken_i;
      ent_d[bus.resolve_tag_i].act_target = bus.resolve_actual_target_i;
    end

    if (mis_fire) begin
      // Tail moves to one past the mispredicting entry; wrap bit follows from head.
      tail_d = head_q + {1'b0, res_off} + PTRW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        rel = TAGW'(i) - head_idx;
        if (({1'b0, rel} > {1'b0, res_off}) && ({1'b0, rel} < occ))
          ent_d[i].valid = 1'b0;
      end
      rec_pulse_d = 1'b1;
      rec_ghr_d   = GH'({r_ent.snap, bus.resolve_actual_taken_i});
      redirect_d  = bus.resolve_actual_taken_i ? bus.resolve_actual_target_i
                                               : (r_ent.pc + 32'd4);
    end

    if (alloc_fire) begin
      ent_d[tail_idx].valid       = 1'b1;
      ent_d[tail_idx].resolved    = 1'b0;
      ent_d[tail_idx].pc          = bus.alloc_pc_i;
      ent_d[tail_idx].pred_taken  = bus.alloc_pred_taken_i;
      ent_d[tail_idx].pred_target = bus.alloc_pred_target_i;
      ent_d[tail_idx].snap        = bus.alloc_ghr_snapshot_i;
      ent_d[tail_idx].act_taken   = 1'b0;
      ent_d[tail_idx].act_target  = '0;
      tail_d = tail_q + PTRW'(1);
    end
  end

  // State and registered output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      train_valid_q  <= 1'b0;
      train_pc_q     <= '0;
      train_taken_q  <= 1'b0;
      train_target_q <= '0;
      train_snap_q   <= '0;
      rec_pulse_q    <= 1'b0;
      rec_ghr_q      <= '0;
      redirect_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      train_valid_q  <= train_valid_d;
      train_pc_q     <= train_pc_d;
      train_taken_q  <= train_taken_d;
      train_target_q <= train_target_d;
      train_snap_q   <= train_snap_d;
      rec_pulse_q    <= rec_pulse_d;
      rec_ghr_q      <= rec_ghr_d;
      redirect_q     <= redirect_d;
    end
  end

`ifdef BRQ_STATS_EN
  logic [31:0] stat_ret_q, stat_ret_d, stat_mis_q, stat_mis_d;

  // Saturating event counters.
  always_comb begin
    stat_ret_d = stat_ret_q;
    stat_mis_d = stat_mis_q;
    if (retire && (stat_ret_q != 32'hFFFF_FFFF))   stat_ret_d = stat_ret_q + 32'd1;
    if (mis_fire && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ret_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_ret_q <= stat_ret_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bus.stat_retired_o    = stat_ret_q;
  assign bus.stat_mispredict_o = stat_mis_q;
`else
  assign bus.stat_retired_o    = 32'd0;
  assign bus.stat_mispredict_o = 32'd0;
`endif

  assign bus.alloc_ready_o              = alloc_ready;
  assign bus.alloc_tag_o                = tail_idx;
  assign bus.train_valid_o              = train_valid_q;
  assign bus.train_pc_o                 = train_pc_q;
  assign bus.train_actual_taken_o       = train_taken_q;
  assign bus.train_actual_target_o      = train_target_q;
  assign bus.train_ghr_snapshot_o       = train_snap_q;
  assign bus.recover_mispredict_pulse_o = rec_pulse_q;
  assign bus.recover_ghr_snapshot_o     = rec_ghr_q;
  assign bus.redirect_pc_o              = redirect_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;
  localparam int GH    = 4;
  localparam int DEPTH = 8;
  localparam int TAGW  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_resolve_queue_if #(.GH(GH), .DEPTH(DEPTH)) bus ();
  branch_resolve_queue #(.GH(GH), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [31:0]   pc;
    logic          tk;
    logic [31:0]   tgt;
    logic [GH-1:0] snap;
  } train_t;
  typedef struct {
    logic [GH-1:0] ghr;
    logic [31:0]   pc;
  } rec_t;

  train_t train_q[$];
  rec_t   rec_q[$];

  logic [31:0]   m_pc   [DEPTH];
  logic          m_pt   [DEPTH];
  logic [31:0]   m_ptgt [DEPTH];
  logic [GH-1:0] m_snap [DEPTH];

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;
  int exp_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every train/recover event must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.train_valid_o) begin
        if (train_q.size() == 0) check_eq("train_unexpected", 1, 0);
        else begin
          train_t t;
          t = train_q.pop_front();
          check_eq("train_pc", bus.train_pc_o, t.pc);
          check_eq("train_taken", bus.train_actual_taken_o, t.tk);
          check_eq("train_target", bus.train_actual_target_o, t.tgt);
          check_eq("train_snap", bus.train_ghr_snapshot_o, t.snap);
        end
      end
      if (bus.recover_mispredict_pulse_o) begin
        if (rec_q.size() == 0) check_eq("recover_unexpected", 1, 0);
        else begin
          rec_t rc;
          rc = rec_q.pop_front();
          check_eq("recover_ghr", bus.recover_ghr_snapshot_o, rc.ghr);
          check_eq("redirect_pc", bus.redirect_pc_o, rc.pc);
        end
      end
    end
  end

  task automatic idle();
    bus.alloc_valid_i           = 1'b0;
    bus.alloc_pc_i              = '0;
    bus.alloc_pred_taken_i      = 1'b0;
    bus.alloc_pred_target_i     = '0;
    bus.alloc_ghr_snapshot_i    = '0;
    bus.resolve_valid_i         = 1'b0;
    bus.resolve_tag_i           = '0;
    bus.resolve_actual_taken_i  = 1'b0;
    bus.resolve_actual_target_i = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    train_q.delete();
    rec_q.delete();
    exp_ret = 0;
    exp_mis = 0;
    reset = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                          input logic [GH-1:0] snap, input logic [TAGW-1:0] exp_tag);
    check_eq("alloc_ready", bus.alloc_ready_o, 1);
    check_eq("alloc_tag", bus.alloc_tag_o, exp_tag);
    bus.alloc_valid_i        = 1'b1;
    bus.alloc_pc_i           = pc;
    bus.alloc_pred_taken_i   = pt;
    bus.alloc_pred_target_i  = tgt;
    bus.alloc_ghr_snapshot_i = snap;
    m_pc[exp_tag]   = pc;
    m_pt[exp_tag]   = pt;
    m_ptgt[exp_tag] = tgt;
    m_snap[exp_tag] = snap;
    tick();
    idle();
  endtask

  // Resolve from the bench's record of the allocated entry; accept says whether it should take effect.
  task automatic do_resolve(input logic [TAGW-1:0] tag, input logic at, input logic [31:0] atgt,
                            input logic accept);
    logic mis;
    bus.resolve_valid_i         = 1'b1;
    bus.resolve_tag_i           = tag;
    bus.resolve_actual_taken_i  = at;
    bus.resolve_actual_target_i = atgt;
    if (accept) begin
      train_t t;
      mis = (m_pt[tag] != at) || (m_pt[tag] && at && (m_ptgt[tag] != atgt));
      t.pc = m_pc[tag]; t.tk = at; t.tgt = atgt; t.snap = m_snap[tag];
      train_q.push_back(t);
      exp_ret++;
      if (mis) begin
        rec_t rc;
        rc.ghr = {m_snap[tag][GH-2:0], at};
        rc.pc  = at ? atgt : m_pc[tag] + 32'd4;
        rec_q.push_back(rc);
        exp_mis++;
      end
    end
    tick();
    idle();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((train_q.size() != 0 || rec_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    tick();
    check_eq({tag, "_train_left"}, train_q.size(), 0);
    check_eq({tag, "_recover_left"}, rec_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef BRQ_STATS_EN
    check_eq({tag, "_stat_retired"}, bus.stat_retired_o, exp_ret);
    check_eq({tag, "_stat_mispredict"}, bus.stat_mispredict_o, exp_mis);
`else
    check_eq({tag, "_stat_retired"}, bus.stat_retired_o, 0);
    check_eq({tag, "_stat_mispredict"}, bus.stat_mispredict_o, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, bus.alloc_ready_o, 1);
    check_eq({tag, "_tag"}, bus.alloc_tag_o, 0);
    check_eq({tag, "_train_valid"}, bus.train_valid_o, 0);
    check_eq({tag, "_train_pc"}, bus.train_pc_o, 0);
    check_eq({tag, "_pulse"}, bus.recover_mispredict_pulse_o, 0);
    check_eq({tag, "_ghr"}, bus.recover_ghr_snapshot_o, 0);
    check_eq({tag, "_redirect"}, bus.redirect_pc_o, 0);
    check_eq({tag, "_stat_retired"}, bus.stat_retired_o, 0);
    check_eq({tag, "_stat_mispredict"}, bus.stat_mispredict_o, 0);
  endtask

  initial begin
    idle();
    do_reset();
    check_reset_outputs("rst");

    // Correct not-taken prediction: train two cycles after resolve, no recovery.
    do_alloc(32'h40, 1'b0, 32'h0, 4'h0, 3'd0);
    do_resolve(3'd0, 1'b0, 32'h0, 1'b1);
    check_eq("nt_train_early", bus.train_valid_o, 0);
    check_eq("nt_pulse", bus.recover_mispredict_pulse_o, 0);
    tick();
    check_eq("nt_train_valid", bus.train_valid_o, 1);
    check_eq("nt_train_pc", bus.train_pc_o, 32'h40);

    // Predicted taken, actually not taken.
    do_alloc(32'h80, 1'b1, 32'h800, 4'h3, 3'd1);
    do_resolve(3'd1, 1'b0, 32'h0, 1'b1);
    check_eq("dir_pulse", bus.recover_mispredict_pulse_o, 1);
    check_eq("dir_ghr", bus.recover_ghr_snapshot_o, 4'h6);
    check_eq("dir_redirect", bus.redirect_pc_o, 32'h84);
    tick();
    check_eq("dir_pulse_once", bus.recover_mispredict_pulse_o, 0);
    check_eq("dir_redirect_hold", bus.redirect_pc_o, 32'h84);

    // Taken both ways, wrong target.
    do_alloc(32'h100, 1'b1, 32'h800, 4'h5, 3'd2);
    do_resolve(3'd2, 1'b1, 32'h888, 1'b1);
    check_eq("tgt_pulse", bus.recover_mispredict_pulse_o, 1);
    check_eq("tgt_redirect", bus.redirect_pc_o, 32'h888);
    drain("early");
    check_stats("early");

    // Fill to DEPTH, overflow attempt, then retire one and wrap the tail.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      do_alloc(32'h1000 + 32'(i) * 32'd4, 1'b0, 32'h0, GH'(i), TAGW'(i));
    check_eq("full_ready", bus.alloc_ready_o, 0);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_pc_i    = 32'hDEAD;
    tick();
    idle();
    check_eq("full_ignored_ready", bus.alloc_ready_o, 0);
    check_eq("full_ignored_tag", bus.alloc_tag_o, 0);
    do_resolve(3'd0, 1'b0, 32'h0, 1'b1);
    check_eq("full_retire_nobypass", bus.alloc_ready_o, 0);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_pc_i    = 32'hBEEF;
    tick();
    idle();
    check_eq("wrap_ready", bus.alloc_ready_o, 1);
    check_eq("wrap_tag", bus.alloc_tag_o, 0);
    do_alloc(32'h2000, 1'b0, 32'h0, 4'h9, 3'd0);
    check_eq("refull_ready", bus.alloc_ready_o, 0);
    drain("full");
    check_stats("full");

    // Squash younger entries on a mid-queue mispredict; same-cycle alloc dropped.
    do_reset();
    for (int i = 0; i < 5; i++)
      do_alloc(32'h200 + 32'(i) * 32'h10, 1'b0, 32'h0, GH'(i), TAGW'(i));
    do_resolve(3'd0, 1'b0, 32'h0, 1'b1);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_pc_i    = 32'hBAD0;
    do_resolve(3'd1, 1'b1, 32'h300, 1'b1);
    check_eq("squash_tag", bus.alloc_tag_o, 2);
    do_resolve(3'd3, 1'b1, 32'h999, 1'b0);
    check_eq("squash_ignored_tag", bus.alloc_tag_o, 2);
    drain("squash");
    check_stats("squash");
    do_alloc(32'h400, 1'b0, 32'h0, 4'h1, 3'd2);
    do_resolve(3'd2, 1'b0, 32'h0, 1'b1);
    drain("post_squash");
    check_stats("post_squash");

    // Reset with pending entries and a same-cycle mispredict.
    for (int i = 0; i < 3; i++)
      do_alloc(32'h600 + 32'(i) * 32'd4, 1'b1, 32'h700, GH'(i), TAGW'(3 + i));
    bus.resolve_valid_i         = 1'b1;
    bus.resolve_tag_i           = 3'd3;
    bus.resolve_actual_taken_i  = 1'b0;
    reset = 1'b1;
    tick();
    idle();
    train_q.delete();
    rec_q.delete();
    exp_ret = 0;
    exp_mis = 0;
    reset = 1'b0;
    check_reset_outputs("midrst");
    repeat (6) tick();
    check_eq("midrst_tag_after", bus.alloc_tag_o, 0);
    check_eq("midrst_ready_after", bus.alloc_ready_o, 1);
    check_stats("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
